// File: rtl/hwpe_ctrl_uloop_seq.sv
// rtl/hwpe_ctrl_uloop_seq.sv - job sequencer driving hwpe_ctrl_uloop and issuing offset/index jobs
// Bounds issued-but-unacked jobs, drains all acks, then pulses done_o.
module hwpe_ctrl_uloop_seq #(
    parameter int unsigned NB_REG       = 4,
    parameter int unsigned REG_WIDTH    = 32,
    parameter int unsigned NB_LOOPS     = 6,
    parameter int unsigned CNT_WIDTH    = 16,
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    input  logic                          start_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          err_o,
    output logic                          uloop_clear_o,
    output logic                          uloop_enable_o,
    input  logic                          uloop_valid_i,
    input  logic                          uloop_done_i,
    input  logic [NB_REG*REG_WIDTH-1:0]   uloop_offs_i,
    input  logic [NB_LOOPS*CNT_WIDTH-1:0] uloop_idx_i,
    output logic                          job_valid_o,
    input  logic                          job_ready_i,
    output logic [NB_REG*REG_WIDTH-1:0]   job_offs_o,
    output logic [NB_LOOPS*CNT_WIDTH-1:0] job_idx_o,
    output logic                          job_last_o,
    input  logic                          job_ack_i,
    output logic [31:0]                   jobs_issued_o
);

    localparam int unsigned IW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [IW-1:0] MAX_CNT = IW'(MAX_INFLIGHT);
    localparam logic [IW-1:0] ONE     = IW'(1);

    typedef enum logic [2:0] {IDLE, INIT, ADVANCE, ISSUE, DRAIN, FINISH} state_e;

    state_e                          state_q, state_d;
    logic [IW-1:0]                   inflight_q, inflight_d;
    logic [31:0]                     issued_q, issued_d;
    logic                            err_q, err_d;
    logic [NB_REG*REG_WIDTH-1:0]     offs_q, offs_d;
    logic [NB_LOOPS*CNT_WIDTH-1:0]   idx_q, idx_d;
    logic                            last_q, last_d;
    logic                            not_full, accept, ack_ok;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            inflight_q <= '0;
            issued_q   <= '0;
            err_q      <= 1'b0;
            offs_q     <= '0;
            idx_q      <= '0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            issued_q   <= issued_d;
            err_q      <= err_d;
            offs_q     <= offs_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        inflight_d     = inflight_q;
        issued_d       = issued_q;
        err_d          = err_q;
        offs_d         = offs_q;
        idx_d          = idx_q;
        last_d         = last_q;
        busy_o         = (state_q != IDLE);
        done_o         = 1'b0;
        uloop_clear_o  = 1'b0;
        uloop_enable_o = 1'b0;
        job_valid_o    = 1'b0;

        not_full = (inflight_q < MAX_CNT);
        accept   = (state_q == ISSUE) && job_ready_i;
        // Acks outside a run, or with nothing outstanding, are protocol errors.
        ack_ok   = job_ack_i && (state_q != IDLE) && (inflight_q != '0);

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d  = INIT;
                    issued_d = '0;
                    err_d    = 1'b0;
                end
            end
            INIT: begin
                uloop_clear_o = 1'b1;
                state_d       = ADVANCE;
            end
            ADVANCE: begin
                uloop_enable_o = not_full;
                if (not_full && uloop_valid_i) begin
                    offs_d  = uloop_offs_i;
                    idx_d   = uloop_idx_i;
                    last_d  = uloop_done_i;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                job_valid_o = 1'b1;
                if (job_ready_i) begin
                    issued_d = issued_q + 32'd1;
                    state_d  = last_q ? DRAIN : ADVANCE;
                end
            end
            DRAIN: begin
                if (inflight_q == '0) state_d = FINISH;
            end
            FINISH: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (job_ack_i && !ack_ok) err_d = 1'b1;

        case ({accept, ack_ok})
            2'b10:   inflight_d = inflight_q + ONE;
            2'b01:   inflight_d = inflight_q - ONE;
            default: inflight_d = inflight_q;
        endcase

        // Soft clear overrides everything decided above.
        if (clear_i) begin
            state_d        = IDLE;
            inflight_d     = '0;
            issued_d       = '0;
            err_d          = 1'b0;
            offs_d         = '0;
            idx_d          = '0;
            last_d         = 1'b0;
            busy_o         = 1'b0;
            done_o         = 1'b0;
            uloop_enable_o = 1'b0;
            job_valid_o    = 1'b0;
            uloop_clear_o  = 1'b1;
        end
    end

    assign err_o         = err_q;
    assign job_offs_o    = offs_q;
    assign job_idx_o     = idx_q;
    assign job_last_o    = last_q;
    assign jobs_issued_o = issued_q;

endmodule

// File: tb/tb_hwpe_ctrl_uloop_seq.sv
// tb/tb_hwpe_ctrl_uloop_seq.sv - scoreboard bench for hwpe_ctrl_uloop_seq
module tb_hwpe_ctrl_uloop_seq;
    localparam int OW = 128;
    localparam int XW = 96;

    typedef struct packed {
        logic [OW-1:0] offs;
        logic [XW-1:0] idx;
        logic          last;
    } job_t;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          clear_i = 1'b0;
    logic          start_i = 1'b0;
    logic          busy_o, done_o, err_o, uloop_clear_o, uloop_enable_o;
    logic          uloop_valid_i = 1'b0;
    logic          uloop_done_i = 1'b1;
    logic [OW-1:0] uloop_offs_i = '0;
    logic [XW-1:0] uloop_idx_i = '0;
    logic          job_valid_o;
    logic          job_ready_i = 1'b0;
    logic [OW-1:0] job_offs_o;
    logic [XW-1:0] job_idx_o;
    logic          job_last_o;
    logic          job_ack_i;
    logic [31:0]   jobs_issued_o;

    logic          auto_ack = 1'b0;
    logic          man_ack = 1'b0;
    logic [1:0]    ack_sh = 2'b00;
    logic          acc_pend = 1'b0;
    logic          stall_prev = 1'b0;
    job_t          stall_pl, mon_cur, mon_exp;
    job_t          set_q[$];
    job_t          exp_q[$];
    int            checks = 0, failures = 0;
    int            accepts = 0, dones = 0, advances = 0;
    int            a0, d0, v0;

    hwpe_ctrl_uloop_seq #(
        .NB_REG(4), .REG_WIDTH(32), .NB_LOOPS(6), .CNT_WIDTH(16), .MAX_INFLIGHT(2)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .uloop_clear_o(uloop_clear_o), .uloop_enable_o(uloop_enable_o),
        .uloop_valid_i(uloop_valid_i), .uloop_done_i(uloop_done_i),
        .uloop_offs_i(uloop_offs_i), .uloop_idx_i(uloop_idx_i),
        .job_valid_o(job_valid_o), .job_ready_i(job_ready_i),
        .job_offs_o(job_offs_o), .job_idx_o(job_idx_o), .job_last_o(job_last_o),
        .job_ack_i(job_ack_i), .jobs_issued_o(jobs_issued_o)
    );

    always #5 clk = ~clk;

    assign job_ack_i = (auto_ack & ack_sh[1]) | man_ack;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_set(input logic [OW-1:0] o, input logic [XW-1:0] x, input logic l);
        set_q.push_back({o, x, l});
        exp_q.push_back({o, x, l});
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int n, input string name);
        for (int i = 0; i < 300 && dones < n; i++) cyc();
        check(name, dones, n);
    endtask

    // uloop model: answers an advance request with the next queued set.
    always @(negedge clk) begin
        if (uloop_valid_i) begin
            uloop_valid_i = 1'b0;
            uloop_done_i  = 1'b1;
            advances++;
            set_q.delete(0);
        end else if (uloop_enable_o && set_q.size() > 0) begin
            uloop_valid_i = 1'b1;
            uloop_offs_i  = set_q[0].offs;
            uloop_idx_i   = set_q[0].idx;
            uloop_done_i  = set_q[0].last;
        end
    end

    always @(posedge clk) begin
        #1;
        ack_sh   = {ack_sh[0], acc_pend};
        acc_pend = 1'b0;
    end

    // Monitor: scoreboard pop on accept, payload stability on stall, done count.
    always @(negedge clk) begin
        if (rst_ni) begin
            mon_cur = {job_offs_o, job_idx_o, job_last_o};
            if (stall_prev) begin
                check("stall_valid", job_valid_o, 1);
                check("stall_payload", mon_cur, stall_pl);
            end
            stall_prev = job_valid_o && !job_ready_i;
            stall_pl   = mon_cur;
            if (job_valid_o && job_ready_i) begin
                accepts++;
                acc_pend = 1'b1;
                if (exp_q.size() == 0) begin
                    check("unexpected_job", 1, 0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("job_offs", job_offs_o, mon_exp.offs);
                    check("job_idx", job_idx_o, mon_exp.idx);
                    check("job_last", job_last_o, mon_exp.last);
                end
            end
            if (done_o) dones++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
        check("rst_enable", uloop_enable_o, 0);
        check("rst_job_valid", job_valid_o, 0);
        check("rst_uloop_clear", uloop_clear_o, 0);
        check("rst_issued", jobs_issued_o, 0);
        cyc();
        rst_ni = 1'b1;

        // Three sets, ready always high, acks two cycles after accept
        auto_ack = 1'b1;
        job_ready_i = 1'b1;
        push_set(128'h00000013_00000012_00000011_00000010, 96'h0000_0000_0000_0000_0000_0000, 1'b0);
        push_set(128'h00000023_00000022_00000021_00000020, 96'h0000_0000_0000_0000_0000_0001, 1'b0);
        push_set(128'h00000033_00000032_00000031_00000030, 96'h0000_0000_0000_0000_0000_0002, 1'b1);
        cyc();
        pulse_start();
        @(negedge clk);
        check("init_uloop_clear", uloop_clear_o, 1);
        check("init_enable", uloop_enable_o, 0);
        check("init_busy", busy_o, 1);
        cyc();
        @(negedge clk);
        check("start_to_enable_2cyc", uloop_enable_o, 1);
        wait_done(1, "s1_done");
        repeat (3) cyc();
        check("s1_done_once", dones, 1);
        check("s1_issued", jobs_issued_o, 3);
        check("s1_busy", busy_o, 0);
        check("s1_err", err_o, 0);
        check("s1_advances", advances, 3);

        // Acks withheld: in-flight limit of 2, then clear while draining
        auto_ack = 1'b0;
        a0 = accepts; d0 = dones; v0 = advances;
        push_set(128'h00000043_00000042_00000041_00000040, 96'h0000_0000_0001_0000_0000_0000, 1'b0);
        push_set(128'h00000053_00000052_00000051_00000050, 96'h0000_0000_0002_0000_0000_0000, 1'b0);
        push_set(128'h00000063_00000062_00000061_00000060, 96'h0000_0000_0003_0000_0000_0000, 1'b1);
        pulse_start();
        for (int i = 0; i < 100 && accepts < a0 + 2; i++) cyc();
        check("s2_two_accepts", accepts, a0 + 2);
        repeat (2) cyc();
        @(negedge clk);
        check("s2_full_enable_low", uloop_enable_o, 0);
        check("s2_full_busy", busy_o, 1);
        check("s2_no_extra_advance", advances, v0 + 2);
        cyc();
        man_ack = 1'b1;
        cyc();
        man_ack = 1'b0;
        @(negedge clk);
        check("s2_enable_reasserts", uloop_enable_o, 1);
        check("s2_err", err_o, 0);
        for (int i = 0; i < 100 && accepts < a0 + 3; i++) cyc();
        check("s2_third_accept", accepts, a0 + 3);
        cyc();
        @(negedge clk);
        check("s2_drain_busy", busy_o, 1);
        check("s2_drain_enable", uloop_enable_o, 0);
        check("s2_drain_issued", jobs_issued_o, 3);
        cyc();
        clear_i = 1'b1;
        cyc();
        clear_i = 1'b0;
        @(negedge clk);
        check("clr_busy", busy_o, 0);
        check("clr_issued", jobs_issued_o, 0);
        check("clr_err", err_o, 0);
        check("clr_job_last", job_last_o, 0);
        repeat (3) cyc();
        check("clr_no_done", dones, d0);

        // Ack while idle is an error that persists until the next start
        man_ack = 1'b1;
        cyc();
        man_ack = 1'b0;
        @(negedge clk);
        check("idle_ack_err", err_o, 1);
        repeat (3) cyc();
        check("idle_ack_err_sticky", err_o, 1);

        // Ready held low five cycles during ISSUE
        auto_ack = 1'b1;
        job_ready_i = 1'b0;
        d0 = dones; v0 = advances;
        push_set(128'h00000073_00000072_00000071_00000070, 96'h0005_0000_0000_0000_0000_0004, 1'b0);
        push_set(128'h00000083_00000082_00000081_00000080, 96'h0006_0000_0000_0000_0000_0005, 1'b1);
        pulse_start();
        @(negedge clk);
        check("start_clears_err", err_o, 0);
        for (int i = 0; i < 100 && !job_valid_o; i++) cyc();
        check("s3_valid_up", job_valid_o, 1);
        repeat (5) cyc();
        check("s3_held_valid", job_valid_o, 1);
        check("s3_single_advance", advances, v0 + 1);
        job_ready_i = 1'b1;
        wait_done(d0 + 1, "s3_done");
        check("s3_issued", jobs_issued_o, 2);

        // Accept and ack in the same cycle with one job in flight
        auto_ack = 1'b0;
        job_ready_i = 1'b0;
        d0 = dones;
        push_set(128'h00000093_00000092_00000091_00000090, 96'h0000_0007_0000_0000_0000_0006, 1'b0);
        push_set(128'h000000a3_000000a2_000000a1_000000a0, 96'h0000_0008_0000_0000_0000_0007, 1'b1);
        pulse_start();
        for (int i = 0; i < 100 && !job_valid_o; i++) cyc();
        check("s4_job1_valid", job_valid_o, 1);
        job_ready_i = 1'b1;
        cyc();
        job_ready_i = 1'b0;
        for (int i = 0; i < 100 && !job_valid_o; i++) cyc();
        check("s4_job2_valid", job_valid_o, 1);
        job_ready_i = 1'b1;
        man_ack = 1'b1;
        cyc();
        job_ready_i = 1'b0;
        man_ack = 1'b0;
        repeat (3) cyc();
        @(negedge clk);
        check("s4_no_err", err_o, 0);
        check("s4_still_draining", busy_o, 1);
        check("s4_no_early_done", dones, d0);
        cyc();
        man_ack = 1'b1;
        cyc();
        man_ack = 1'b0;
        wait_done(d0 + 1, "s4_done");
        check("s4_err_final", err_o, 0);
        check("s4_issued", jobs_issued_o, 2);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
